// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS main FSM (master) and the datapath (slave).
interface mips_multicycle_ctrl_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsrc;
   logic       pcwrite;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, aluop, pcsrc, pcwrite, illegal_op, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, aluop, pcsrc, pcwrite, illegal_op, state
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (lw, sw, R-type, beq, j).
// Define MCCTRL_ADDI_EN to add addi support (states ADDIEX/ADDIWB, opcode 001000).
module mips_multicycle_ctrl (
   input  logic                          clk,
   input  logic                          rst_n,
   mips_multicycle_ctrl_if.master        bus
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BEQ    = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MCCTRL_ADDI_EN
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0] state_q, state_d;

   logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
   logic       alusrca, pcwrite, illegal_op;
   logic [1:0] alusrcb, aluop, pcsrc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      iord       = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            irwrite = bus.mem_ready;
            pcwrite = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JUMP;
`ifdef MCCTRL_ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            memread = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = bus.mem_ready;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQ: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            pcwrite = bus.zero;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
            state_d = S_FETCH;
         end
`ifdef MCCTRL_ADDI_EN
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;
      endcase

      // Reset already parks state in FETCH; strobes are killed combinationally
      // so an assertion mid-access drops them in the same cycle.
      if (!rst_n) begin
         memread    = 1'b0;
         memwrite   = 1'b0;
         irwrite    = 1'b0;
         pcwrite    = 1'b0;
         regwrite   = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign bus.iord       = iord;
   assign bus.memread    = memread;
   assign bus.memwrite   = memwrite;
   assign bus.irwrite    = irwrite;
   assign bus.regdst     = regdst;
   assign bus.memtoreg   = memtoreg;
   assign bus.regwrite   = regwrite;
   assign bus.alusrca    = alusrca;
   assign bus.alusrcb    = alusrcb;
   assign bus.aluop      = aluop;
   assign bus.pcsrc      = pcsrc;
   assign bus.pcwrite    = pcwrite;
   assign bus.illegal_op = illegal_op;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle scoreboard bench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;

   logic clk;
   logic rst_n;
   int   nchk;
   int   nerr;

   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic        z;
      logic        mr;
      logic [19:0] exp;
   } ent_t;

   ent_t sb[$];

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AD = 6'b001000;
   localparam logic [5:0] BAD = 6'b111111;

   // {iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
   //  alusrcb,aluop,pcsrc,pcwrite,illegal_op,state}
   function automatic logic [19:0] ex(input int unsigned st, input logic mr,
                                      input logic z, input logic ill, input logic inrst);
      logic iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcw;
      logic [1:0] srcb, aop, psrc;
      logic [3:0] s4;
      {iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcw} = '0;
      srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
      s4 = 4'(st);
      case (st)
         0:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
         1:  srcb = 2'b11;
         2:  begin asa = 1'b1; srcb = 2'b10; end
         3:  begin iord = 1'b1; mrd = 1'b1; end
         4:  begin m2r = 1'b1; rw = 1'b1; end
         5:  begin iord = 1'b1; mwr = mr; end
         6:  begin asa = 1'b1; aop = 2'b10; end
         7:  begin rdst = 1'b1; rw = 1'b1; end
         8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcw = z; end
         9:  begin psrc = 2'b10; pcw = 1'b1; end
         10: begin asa = 1'b1; srcb = 2'b10; end
         11: rw = 1'b1;
         default: ;
      endcase
      if (inrst) begin mrd = 1'b0; mwr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; end
      return {iord, mrd, mwr, irw, rdst, m2r, rw, asa, srcb, aop, psrc, pcw, ill, s4};
   endfunction

   function automatic logic [19:0] obs();
      return {bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
              bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.pcwrite,
              bus.illegal_op, bus.state};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [5:0] op, input int unsigned st, input logic mr,
                       input logic z, input logic ill);
      ent_t e;
      e.op = op; e.z = z; e.mr = mr;
      e.exp = ex(st, mr, z, ill, 1'b0);
      sb.push_back(e);
   endtask

   task automatic test_reset();
      logic [19:0] got, want;
      rst_n = 1'b0; bus.mem_ready = 1'b1; bus.opcode = LW; bus.zero = 1'b0;
      want = ex(0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== want) begin
            nerr++; $display("FAIL reset_hold c%0d: got %h expected %h", i, got, want);
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      push(LW, 0, 1'b1, 1'b0, 1'b0);
      while (sb.size() != 0) begin
         ent_t e = sb.pop_front();
         bus.opcode = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== e.exp) begin
            nerr++; $display("FAIL reset_release: got %h expected %h", got, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw();
      logic [19:0] got;
      // continues from DECODE after the fetch issued in test_reset
      push(LW, 1, rb(), rb(), 1'b0);
      push(LW, 2, rb(), rb(), 1'b0);
      push(LW, 3, 1'b0, rb(), 1'b0);
      push(LW, 3, 1'b1, rb(), 1'b0);
      push(LW, 4, rb(), rb(), 1'b0);
      push(LW, 0, 1'b1, rb(), 1'b0);
      push(LW, 1, rb(), rb(), 1'b0);
      push(LW, 2, rb(), rb(), 1'b0);
      push(LW, 3, 1'b1, rb(), 1'b0);
      push(LW, 4, rb(), rb(), 1'b0);
      while (sb.size() != 0) begin
         ent_t e = sb.pop_front();
         bus.opcode = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== e.exp) begin
            nerr++; $display("FAIL lw st%0d: got %h expected %h", e.exp[3:0], got, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw_stall();
      logic [19:0] got;
      push(SW, 0, 1'b1, rb(), 1'b0);
      push(SW, 1, rb(), rb(), 1'b0);
      push(SW, 2, rb(), rb(), 1'b0);
      push(SW, 5, 1'b0, rb(), 1'b0);
      push(SW, 5, 1'b0, rb(), 1'b0);
      push(SW, 5, 1'b0, rb(), 1'b0);
      push(SW, 5, 1'b1, rb(), 1'b0);
      while (sb.size() != 0) begin
         ent_t e = sb.pop_front();
         bus.opcode = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== e.exp) begin
            nerr++; $display("FAIL sw_stall st%0d: got %h expected %h", e.exp[3:0], got, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rtype_branch_jump();
      logic [19:0] got;
      push(RT, 0, 1'b0, rb(), 1'b0);
      push(RT, 0, 1'b1, rb(), 1'b0);
      push(RT, 1, rb(), rb(), 1'b0);
      push(RT, 6, rb(), rb(), 1'b0);
      push(RT, 7, rb(), rb(), 1'b0);
      push(BQ, 0, 1'b1, rb(), 1'b0);
      push(BQ, 1, rb(), rb(), 1'b0);
      push(BQ, 8, rb(), 1'b1, 1'b0);
      push(BQ, 0, 1'b1, rb(), 1'b0);
      push(BQ, 1, rb(), rb(), 1'b0);
      push(BQ, 8, rb(), 1'b0, 1'b0);
      push(JJ, 0, 1'b1, rb(), 1'b0);
      push(JJ, 1, rb(), rb(), 1'b0);
      push(JJ, 9, rb(), rb(), 1'b0);
      while (sb.size() != 0) begin
         ent_t e = sb.pop_front();
         bus.opcode = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== e.exp) begin
            nerr++; $display("FAIL rtype_branch_jump st%0d: got %h expected %h", e.exp[3:0], got, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal_addi();
      logic [19:0] got;
      push(BAD, 0, 1'b1, rb(), 1'b0);
      push(BAD, 1, rb(), rb(), 1'b1);
      push(AD,  0, 1'b1, rb(), 1'b0);
`ifdef MCCTRL_ADDI_EN
      push(AD,  1, rb(), rb(), 1'b0);
      push(AD,  10, rb(), rb(), 1'b0);
      push(AD,  11, rb(), rb(), 1'b0);
`else
      push(AD,  1, rb(), rb(), 1'b1);
`endif
      push(RT,  0, 1'b1, rb(), 1'b0);
      while (sb.size() != 0) begin
         ent_t e = sb.pop_front();
         bus.opcode = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== e.exp) begin
            nerr++; $display("FAIL illegal_addi st%0d: got %h expected %h", e.exp[3:0], got, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_abort();
      logic [19:0] got, want;
      // previous task left the DUT in DECODE with opcode R-type; finish it first
      push(RT, 1, rb(), rb(), 1'b0);
      push(RT, 6, rb(), rb(), 1'b0);
      push(RT, 7, rb(), rb(), 1'b0);
      push(SW, 0, 1'b1, rb(), 1'b0);
      push(SW, 1, rb(), rb(), 1'b0);
      push(SW, 2, rb(), rb(), 1'b0);
      push(SW, 5, 1'b1, rb(), 1'b0);
      while (sb.size() != 0) begin
         ent_t e = sb.pop_front();
         bus.opcode = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== e.exp) begin
            nerr++; $display("FAIL reset_abort_pre st%0d: got %h expected %h", e.exp[3:0], got, e.exp);
         end
         if (sb.size() != 0) begin
            @(posedge clk); #1;
         end
      end
      #2 rst_n = 1'b0;
      #1;
      want = ex(0, 1'b1, 1'b0, 1'b0, 1'b1);
      got = obs(); nchk++;
      if (got !== want) begin
         nerr++; $display("FAIL reset_abort_async: got %h expected %h", got, want);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      push(SW, 0, 1'b1, rb(), 1'b0);
      push(SW, 1, rb(), rb(), 1'b0);
      while (sb.size() != 0) begin
         ent_t e = sb.pop_front();
         bus.opcode = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
         @(negedge clk);
         got = obs(); nchk++;
         if (got !== e.exp) begin
            nerr++; $display("FAIL reset_abort_post st%0d: got %h expected %h", e.exp[3:0], got, e.exp);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      nchk = 0;
      nerr = 0;
      test_reset();
      test_lw();
      test_sw_stall();
      test_rtype_branch_jump();
      test_illegal_addi();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end

endmodule
